pattern_sweep_gen: RTL
======================

Name: pattern_sweep_gen

Overview:
- Synthesizable exhaustive stimulus generator with a response compactor for combinational lab DUTs.
- Replaces hand-written per-bit toggle delays in testbenches.
- Drives an N-bit input vector through binary, Gray, walking-one or walking-zero sequences, holding each pattern for a fixed settle time.
- Compresses the DUT's R-bit response into a MISR signature for single-value pass/fail checks.

Parameters:
- N, 4, width of the generated pattern (DUT input count), 1..16.
- R, 3, width of the DUT response and signature, 2..16.
- HOLD, 4, clock cycles each pattern is held, >=1.
- POLY, 3'b011, R-bit MISR feedback tap mask.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- abort  in  1  stops a sweep; returns to IDLE on next edge.
- mode  in  2  sequence select: 0 binary, 1 Gray, 2 walking-one, 3 walking-zero; latched at start.
- one_shot  in  1  1 = single pass then DONE; 0 = wrap continuously; latched at start.
- resp  in  R  DUT response to the current pattern.
- pattern  out  N  vector to DUT inputs.
- pattern_valid  out  1  high while pattern is a live sweep value.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- signature  out  R  MISR contents.
- pat_count  out  16  number of resp samples taken this sweep, wraps modulo 2^16.

Behaviour:
- Reset (async, any state): state=IDLE; pattern=0, pattern_valid=0, busy=0, done=0, signature=0, pat_count=0.
- States:
  - IDLE --start--> RUN
  - RUN --last sample && one_shot--> DONE
  - RUN --abort--> IDLE
  - DONE --start--> RUN
  - DONE --abort--> IDLE
- Start: start sampled high at edge k.
  - Edge k latches mode/one_shot and sets idx=0, hold=0, signature=0, pat_count=0.
  - From cycle k+1: busy=1, pattern_valid=1, pattern = first pattern.
- start while in RUN is ignored. abort has priority over start and over completion in the same cycle.
- Index range: LAST = 2^N-1 for modes 0/1; LAST = N-1 for modes 2/3.
- Pattern mapping:
  - mode 0: idx.
  - mode 1: idx ^ (idx>>1).
  - mode 2: 1<<idx.
  - mode 3: ~(1<<idx).
  - pattern is registered and changes only at pattern boundaries.
- Hold: each pattern is presented for exactly HOLD cycles. resp is sampled at the edge ending the HOLD-th cycle (settled value).
- At each sample edge:
  - signature <= ({signature[R-2:0],1'b0} ^ (signature[R-1] ? POLY : 0)) ^ resp.
  - pat_count += 1.
  - hold resets to 0 and idx advances.
- Last sample (idx==LAST):
  - one_shot=1: next cycle state=DONE, busy=0, pattern_valid=0, done=1. pattern and signature hold their final values until the next start.
  - one_shot=0: idx wraps to 0 with no gap cycle. signature and pat_count keep accumulating, and busy stays 1.
- HOLD=1: a new pattern appears every cycle and resp is sampled every cycle.
- Abort: next edge gives IDLE, busy=0, done=0, pattern_valid=0. pattern and signature hold their values; pat_count is frozen.
- Reset mid-RUN: immediate return to reset values; no partial sample is taken.
- mode/one_shot changes during RUN have no effect until the next start.

Test Plan:
- Binary one-shot (N=4, HOLD=4, resp=0): start at cycle 0.
  - pattern steps 0..15, each held 4 cycles; busy high 64 cycles.
  - Then done=1, pat_count=16, signature=0, pattern=4'hF, pattern_valid=0.
- Gray one-shot: pattern sequence begins 0,1,3,2,6,7,5,4 and ends 8 (4'b1000); adjacent patterns differ by exactly one bit; pat_count=16.
- Walking-one one-shot, resp=pattern[2:0], R=3, POLY=3'b011:
  - patterns 1,2,4,8; samples 1,2,4,0.
  - signature evolves 001, 000, 100, 011; final signature=3'b011, pat_count=4.
- Continuous mode with HOLD=1:
  - mode 3 gives pattern E,D,B,7,E,... with no gap at wrap.
  - busy stays 1, done stays 0; after 10 cycles pat_count=10.
- Control corners:
  - start pulsed mid-RUN: no restart, idx unchanged.
  - abort and start in the same cycle: IDLE.
  - start from DONE: signature and pat_count clear, sweep restarts at pattern 0.
- Async rst asserted mid-hold, between clock edges: all outputs go to 0 immediately, without waiting for a clock edge; after release the block idles until start.

Source files
------------

// File: rtl/pattern_sweep_gen.sv
// Exhaustive stimulus generator for combinational lab DUTs: sweeps an N-bit
// pattern (binary/Gray/walking-one/walking-zero) and folds responses into a MISR.
module pattern_sweep_gen #(
    parameter int          N    = 4,
    parameter int          R    = 3,
    parameter int          HOLD = 4,
    parameter logic [R-1:0] POLY = 3'b011
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic          one_shot,
    input  logic [R-1:0]  resp,
    output logic [N-1:0]  pattern,
    output logic          pattern_valid,
    output logic          busy,
    output logic          done,
    output logic [R-1:0]  signature,
    output logic [15:0]   pat_count
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [N-1:0]  IDX_ONE   = N'(1'b1);
    localparam logic [N-1:0]  IDX_ALL   = {N{1'b1}};
    localparam logic [N-1:0]  IDX_WALK  = N'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r, state_nx_s;
    logic [1:0]     mode_r;
    logic           one_shot_r;
    logic [N-1:0]   idx_r;
    logic [HW-1:0]  hold_r;
    logic [N-1:0]   pattern_r;
    logic [R-1:0]   signature_r;
    logic [15:0]    pat_count_r;
    logic           busy_r, done_r, valid_r;
    logic           start_sweep_s, sample_s, last_s;

    // Index-to-pattern mapping shared by sweep start and each pattern boundary.
    function automatic logic [N-1:0] map_pattern(input logic [1:0] m, input logic [N-1:0] i);
        logic [N-1:0] p;
        case (m)
            2'd0:    p = i;
            2'd1:    p = i ^ (i >> 1);
            2'd2:    p = IDX_ONE << i;
            2'd3:    p = ~(IDX_ONE << i);
            default: p = {N{1'b0}};
        endcase
        return p;
    endfunction

    // One MISR step: shift left, fold the tap mask on MSB carry-out, inject response.
    function automatic logic [R-1:0] misr_next(input logic [R-1:0] sig, input logic [R-1:0] din);
        logic [R-1:0] fb;
        if (sig[R-1]) begin
            fb = POLY;
        end else begin
            fb = {R{1'b0}};
        end
        return {sig[R-2:0], 1'b0} ^ fb ^ din;
    endfunction

    // Next-state decode; abort outranks start and sweep completion.
    always_comb begin
        state_nx_s    = state_r;
        start_sweep_s = 1'b0;
        sample_s      = 1'b0;
        if (mode_r[1]) begin
            last_s = (idx_r == IDX_WALK);
        end else begin
            last_s = (idx_r == IDX_ALL);
        end
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (start) begin
                    state_nx_s    = ST_RUN;
                    start_sweep_s = 1'b1;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (hold_r == HOLD_LAST) begin
                    sample_s = 1'b1;
                    if (last_s && one_shot_r) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register, status flags and sweep datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mode_r      <= 2'd0;
            one_shot_r  <= 1'b0;
            idx_r       <= {N{1'b0}};
            hold_r      <= {HW{1'b0}};
            pattern_r   <= {N{1'b0}};
            signature_r <= {R{1'b0}};
            pat_count_r <= 16'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_RUN);
            valid_r <= (state_nx_s == ST_RUN);
            done_r  <= (state_nx_s == ST_DONE);
            if (start_sweep_s) begin
                mode_r      <= mode;
                one_shot_r  <= one_shot;
                idx_r       <= {N{1'b0}};
                hold_r      <= {HW{1'b0}};
                signature_r <= {R{1'b0}};
                pat_count_r <= 16'd0;
                pattern_r   <= map_pattern(mode, {N{1'b0}});
            end else if (sample_s) begin
                signature_r <= misr_next(signature_r, resp);
                pat_count_r <= pat_count_r + 16'd1;
                hold_r      <= {HW{1'b0}};
                if (last_s) begin
                    idx_r <= {N{1'b0}};
                    // A finished one-shot sweep keeps its final pattern on the bus.
                    if (!one_shot_r) begin
                        pattern_r <= map_pattern(mode_r, {N{1'b0}});
                    end
                end else begin
                    idx_r     <= idx_r + IDX_ONE;
                    pattern_r <= map_pattern(mode_r, idx_r + IDX_ONE);
                end
            end else if (state_r == ST_RUN && !abort) begin
                hold_r <= hold_r + HOLD_ONE;
            end
        end
    end

    assign pattern       = pattern_r;
    assign pattern_valid = valid_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign signature     = signature_r;
    assign pat_count     = pat_count_r;

endmodule
